// File: rtl/divider_seq.sv
// divider_seq: sequential unsigned restoring divider.
// Produces one quotient bit per clock. An accepted start with B != 0 yields a result
// N+1 cycles later. A start with B == 0 yields a divide-by-zero result after one cycle.
module divider_seq #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] Q,
   output logic [N-1:0] R,
   output logic         div_by_zero
);

   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   dividend_q;
   logic [N-1:0]   divisor_q;
   logic [N-1:0]   rem_q;
   logic [N-2:0]   quot_q;
   logic [CW-1:0]  cnt_q;

   logic           accept;
   logic [N:0]     rem_shift;
   logic           qbit;
   logic [N-1:0]   rem_next;
   logic [N-1:0]   quot_next;

   // IDLE and DONE both accept a new start, so back-to-back operations lose no cycle
   assign accept = start && (state_q == StIdle || state_q == StDone);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               state_d = (B == '0) ? StDone : StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            if (cnt_q == CW'(1)) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Handshake outputs decoded from the current state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         StRun:   busy = 1'b1;
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   // One restoring step. rem_shift is the N+1 bit partial remainder; after a successful
   // subtraction the result is below the divisor, so an N-bit difference is exact.
   always_comb begin
      rem_shift = {rem_q, dividend_q[N-1]};
      qbit      = (rem_shift >= {1'b0, divisor_q});
      rem_next  = qbit ? (rem_shift[N-1:0] - divisor_q) : rem_shift[N-1:0];
      quot_next = {quot_q, qbit};
   end

   // Datapath: operand latch, iteration registers and the held result
   always_ff @(posedge clk) begin
      if (rst) begin
         dividend_q  <= '0;
         divisor_q   <= '0;
         rem_q       <= '0;
         quot_q      <= '0;
         cnt_q       <= '0;
         Q           <= '0;
         R           <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         dividend_q <= A;
         divisor_q  <= B;
         rem_q      <= '0;
         quot_q     <= '0;
         cnt_q      <= CW'(N);
         if (B == '0) begin
            Q           <= '1;
            R           <= A;
            div_by_zero <= 1'b1;
         end
      end else if (state_q == StRun) begin
         dividend_q <= {dividend_q[N-2:0], 1'b0};
         rem_q      <= rem_next;
         quot_q     <= quot_next[N-2:0];
         cnt_q      <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            Q           <= quot_next;
            R           <= rem_next;
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule
